// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite initiator: one command becomes one AW+W+B write or one AR+R read.
// Define AXI_LITE_MASTER_ID_CHECK_EN to check returned IDs and expose the sticky id_err_o flag.
module axi_lite_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                clk,
  input  logic                areset,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_write_i,
  input  logic [ID_W-1:0]     cmd_id_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [DATA_W-1:0]   cmd_wdata_i,
  input  logic [DATA_W/8-1:0] cmd_wstrb_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic                rsp_write_o,
  output logic [ID_W-1:0]     rsp_id_o,
  output logic [1:0]          rsp_resp_o,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                busy_o,
`ifdef AXI_LITE_MASTER_ID_CHECK_EN
  output logic                id_err_o,
`endif
  output logic [ID_W-1:0]     awid_o,
  output logic [ADDR_W-1:0]   awaddr_o,
  output logic                awvalid_o,
  input  logic                awready_i,
  output logic [ID_W-1:0]     wid_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  output logic                wlast_o,
  output logic                wvalid_o,
  input  logic                wready_i,
  input  logic [ID_W-1:0]     bid_i,
  input  logic [1:0]          bresp_i,
  input  logic                bvalid_i,
  output logic                bready_o,
  output logic [ID_W-1:0]     arid_o,
  output logic [ADDR_W-1:0]   araddr_o,
  output logic                arvalid_o,
  input  logic                arready_i,
  input  logic [ID_W-1:0]     rid_i,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic [1:0]          rresp_i,
  input  logic                rlast_i,
  input  logic                rvalid_i,
  output logic                rready_o
);

  typedef enum logic [2:0] {IDLE, WR, B_WAIT, RD, R_WAIT, RSP} state_t;

  state_t              state_q;
  logic                cmd_ready_q, busy_q;
  logic [ID_W-1:0]     id_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic                awvalid_q, wvalid_q, aw_done_q, w_done_q, bready_q;
  logic                arvalid_q, rready_q, r_got_q;
  logic                rsp_valid_q, rsp_write_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic [1:0]          rsp_resp_q;
  logic [DATA_W-1:0]   rsp_rdata_q;

  // A channel counts as finished if it completed earlier or is handshaking this cycle.
  logic aw_fin, w_fin, b_id_bad, r_id_bad;
  assign aw_fin = aw_done_q | (awvalid_q & awready_i);
  assign w_fin  = w_done_q  | (wvalid_q & wready_i);

`ifdef AXI_LITE_MASTER_ID_CHECK_EN
  logic id_err_q;
  assign b_id_bad = (bid_i != id_q);
  assign r_id_bad = (rid_i != id_q);
  assign id_err_o = id_err_q;
`else
  assign b_id_bad = 1'b0;
  assign r_id_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      id_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      r_got_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_resp_q  <= '0;
      rsp_rdata_q <= '0;
`ifdef AXI_LITE_MASTER_ID_CHECK_EN
      id_err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_ready_q && cmd_valid_i) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            id_q        <= cmd_id_i;
            addr_q      <= cmd_addr_i;
            wdata_q     <= cmd_wdata_i;
            wstrb_q     <= cmd_wstrb_i;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            r_got_q     <= 1'b0;
            if (cmd_write_i) begin
              state_q   <= WR;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= RD;
              arvalid_q <= 1'b1;
            end
          end else begin
            // First cycle out of reset raises ready here.
            cmd_ready_q <= 1'b1;
          end
        end
        WR: begin
          if (awvalid_q && awready_i) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (wvalid_q && wready_i) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            state_q  <= B_WAIT;
            bready_q <= 1'b1;
          end
        end
        B_WAIT: begin
          if (bvalid_i) begin
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_write_q <= 1'b1;
            rsp_id_q    <= bid_i;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= b_id_bad ? 2'b11 : bresp_i;
`ifdef AXI_LITE_MASTER_ID_CHECK_EN
            if (b_id_bad) id_err_q <= 1'b1;
`endif
            state_q     <= RSP;
          end
        end
        RD: begin
          if (arready_i) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (rvalid_i) begin
            if (!r_got_q) begin
              r_got_q     <= 1'b1;
              rsp_write_q <= 1'b0;
              rsp_id_q    <= rid_i;
              rsp_rdata_q <= rdata_i;
              rsp_resp_q  <= r_id_bad ? 2'b11 : rresp_i;
`ifdef AXI_LITE_MASTER_ID_CHECK_EN
              if (r_id_bad) id_err_q <= 1'b1;
`endif
            end else if (rresp_i != 2'b00) begin
              // Extra beats past the first are drained; only an error status survives.
              rsp_resp_q <= rresp_i;
            end
            if (rlast_i) begin
              rready_q    <= 1'b0;
              rsp_valid_q <= 1'b1;
              state_q     <= RSP;
            end
          end
        end
        RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign busy_o      = busy_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_write_o = rsp_write_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_resp_o  = rsp_resp_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign awid_o      = id_q;
  assign awaddr_o    = addr_q;
  assign awvalid_o   = awvalid_q;
  assign wid_o       = id_q;
  assign wdata_o     = wdata_q;
  assign wstrb_o     = wstrb_q;
  assign wlast_o     = wvalid_q;
  assign wvalid_o    = wvalid_q;
  assign bready_o    = bready_q;
  assign arid_o      = id_q;
  assign araddr_o    = addr_q;
  assign arvalid_o   = arvalid_q;
  assign rready_o    = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed plus randomized bench for axi_lite_master; a behavioural slave/response model lives here.
`timescale 1ns/1ps
module tb_axi_lite_master;
  localparam int AW = 32, DW = 32, IW = 4;

  logic clk = 1'b0, areset = 1'b1;
  always #5 clk = ~clk;

  logic cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [IW-1:0] cmd_id_i;
  logic [AW-1:0] cmd_addr_i;
  logic [DW-1:0] cmd_wdata_i;
  logic [DW/8-1:0] cmd_wstrb_i;
  logic rsp_valid_o, rsp_ready_i, rsp_write_o, busy_o;
  logic [IW-1:0] rsp_id_o;
  logic [1:0] rsp_resp_o;
  logic [DW-1:0] rsp_rdata_o;
  logic [IW-1:0] awid_o, wid_o, bid_i, arid_o, rid_i;
  logic [AW-1:0] awaddr_o, araddr_o;
  logic [DW-1:0] wdata_o, rdata_i;
  logic [DW/8-1:0] wstrb_o;
  logic awvalid_o, awready_i, wlast_o, wvalid_o, wready_i;
  logic [1:0] bresp_i, rresp_i;
  logic bvalid_i, bready_o, arvalid_o, arready_i, rlast_i, rvalid_i, rready_o;
`ifdef AXI_LITE_MASTER_ID_CHECK_EN
  logic id_err_o;
`endif

  int total = 0, bad = 0, ntx = 0;
  bit preload = 0;

  axi_lite_master #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .areset(areset),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_id_i(cmd_id_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_wstrb_i(cmd_wstrb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_write_o(rsp_write_o),
    .rsp_id_o(rsp_id_o), .rsp_resp_o(rsp_resp_o), .rsp_rdata_o(rsp_rdata_o), .busy_o(busy_o),
`ifdef AXI_LITE_MASTER_ID_CHECK_EN
    .id_err_o(id_err_o),
`endif
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wid_o(wid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o),
    .wready_i(wready_i),
    .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .arid_o(arid_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i), .rvalid_i(rvalid_i),
    .rready_o(rready_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    awready_i = 0; wready_i = 0; bvalid_i = 0; bid_i = '0; bresp_i = '0;
    arready_i = 0; rvalid_i = 0; rid_i = '0; rdata_i = '0; rresp_i = '0; rlast_i = 0;
  endtask

  // Called at a negedge; returns at the negedge of the first cycle after acceptance.
  task automatic issue_cmd(input logic wr, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic [DW/8-1:0] strb);
    int t;
    t = 0;
    cmd_valid_i = 1; cmd_write_i = wr; cmd_id_i = id; cmd_addr_i = addr;
    cmd_wdata_i = data; cmd_wstrb_i = strb;
    while (!cmd_ready_o && t < 50) begin @(negedge clk); t++; end
    if (t == 50) chk("cmd_accept_timeout", {63'd0, cmd_ready_o}, 64'd1);
    @(negedge clk);
    cmd_valid_i = 0; cmd_write_i = $urandom_range(0, 1); cmd_id_i = $urandom;
    cmd_addr_i = $urandom; cmd_wdata_i = $urandom; cmd_wstrb_i = $urandom;
  endtask

  // Entered at the negedge where rsp_valid_o should first be visible.
  task automatic take_rsp(input logic exp_wr, input logic [IW-1:0] exp_id, input logic [1:0] exp_resp,
                          input logic [DW-1:0] exp_rdata, input int hold);
    if (preload) cmd_valid_i = 1;
    rsp_ready_i = 0;
    chk("rsp_first", {rsp_valid_o, rsp_write_o, rsp_id_o, rsp_resp_o, rsp_rdata_o, cmd_ready_o, busy_o},
        {1'b1, exp_wr, exp_id, exp_resp, exp_rdata, 1'b0, 1'b1});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("rsp_hold", {rsp_valid_o, rsp_write_o, rsp_id_o, rsp_resp_o, rsp_rdata_o, cmd_ready_o, busy_o},
          {1'b1, exp_wr, exp_id, exp_resp, exp_rdata, 1'b0, 1'b1});
    end
    rsp_ready_i = 1;
    @(negedge clk);
    rsp_ready_i = 0;
    chk("rsp_done", {61'd0, rsp_valid_o, cmd_ready_o, busy_o}, 64'b010);
    $display("txn %0d wr=%0b id=%0d resp=%0d rdata=%h hold=%0d", ntx, exp_wr, exp_id, exp_resp, exp_rdata, hold);
    ntx++;
  endtask

  task automatic do_write(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [DW/8-1:0] strb, input int awd, input int wd, input int bd,
                          input logic [1:0] bresp, input logic [IW-1:0] bid_r, input int hold,
                          input bit early_b, output int lat);
    bit aw_ok, w_ok, b_ok, aw_hs, w_hs, b_hs;
    int bw, cyc;
    logic [1:0] exp_resp;
    aw_ok = 0; w_ok = 0; b_ok = 0; bw = 0; cyc = 1;
`ifdef AXI_LITE_MASTER_ID_CHECK_EN
    exp_resp = (bid_r != id) ? 2'b11 : bresp;
`else
    exp_resp = bresp;
`endif
    issue_cmd(1'b1, id, addr, data, strb);
    while (!b_ok && cyc < 200) begin
      chk("wr_ctl", {56'd0, awvalid_o, wvalid_o, bready_o, rsp_valid_o, arvalid_o, rready_o, cmd_ready_o, busy_o},
          {56'd0, ~aw_ok, ~w_ok, aw_ok & w_ok, 5'b00001});
      if (!aw_ok) chk("aw_payload", {awid_o, awaddr_o}, {id, addr});
      if (!w_ok) chk("w_payload", {wid_o, wlast_o, wstrb_o, wdata_o}, {id, 1'b1, strb, data});
      awready_i = (cyc >= 1 + awd);
      wready_i  = (cyc >= 1 + wd);
      bid_i = bid_r; bresp_i = bresp;
      if (aw_ok && w_ok) begin bvalid_i = (bw >= bd); bw++; end
      else bvalid_i = early_b && ($urandom_range(0, 1) == 1);
      aw_hs = awready_i && awvalid_o;
      w_hs  = wready_i && wvalid_o;
      b_hs  = bvalid_i && bready_o;
      @(negedge clk);
      cyc++;
      if (aw_hs) aw_ok = 1;
      if (w_hs) w_ok = 1;
      if (b_hs) b_ok = 1;
    end
    slave_idle();
    lat = cyc;
    if (!b_ok) chk("wr_timeout", {63'd0, b_ok}, 64'd1);
    take_rsp(1'b1, bid_r, exp_resp, '0, hold);
  endtask

  task automatic do_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int ard, input int rgap,
                         input int nbeats, input logic [DW-1:0] d0, input logic [1:0] r0,
                         input logic [IW-1:0] rid_r, input int hold, output int lat);
    logic [DW-1:0] bdat [4];
    logic [1:0] bres [4];
    logic [1:0] exp_resp;
    bit ar_ok, done, a_hs, r_hs;
    int beat, gap, cyc;
    for (int k = 0; k < 4; k++) begin
      bdat[k] = (k == 0) ? d0 : $urandom;
      bres[k] = (k == 0) ? r0 : (($urandom_range(0, 1) == 1) ? 2'b00 : 2'($urandom_range(1, 3)));
    end
    // Reference: first beat's status, replaced by any later non-OKAY beat.
`ifdef AXI_LITE_MASTER_ID_CHECK_EN
    exp_resp = (rid_r != id) ? 2'b11 : r0;
`else
    exp_resp = r0;
`endif
    for (int k = 1; k < nbeats; k++) if (bres[k] != 2'b00) exp_resp = bres[k];
    ar_ok = 0; done = 0; beat = 0; gap = 0; cyc = 1;
    issue_cmd(1'b0, id, addr, $urandom, $urandom);
    while (!done && cyc < 300) begin
      chk("rd_ctl", {56'd0, arvalid_o, rready_o, rsp_valid_o, awvalid_o, wvalid_o, bready_o, cmd_ready_o, busy_o},
          {56'd0, ~ar_ok, ar_ok, 6'b000001});
      if (!ar_ok) chk("ar_payload", {arid_o, araddr_o}, {id, addr});
      arready_i = (cyc >= 1 + ard);
      rvalid_i = 0;
      if (ar_ok) begin
        if (gap >= rgap) begin
          rvalid_i = 1; rid_i = rid_r; rdata_i = bdat[beat]; rresp_i = bres[beat];
          rlast_i = (beat == nbeats - 1);
        end else gap++;
      end
      a_hs = arready_i && arvalid_o;
      r_hs = rvalid_i && rready_o;
      @(negedge clk);
      cyc++;
      if (a_hs) ar_ok = 1;
      if (r_hs) begin beat++; gap = 0; if (beat == nbeats) done = 1; end
    end
    slave_idle();
    lat = cyc;
    if (!done) chk("rd_timeout", {63'd0, done}, 64'd1);
    take_rsp(1'b0, rid_r, exp_resp, d0, hold);
  endtask

  initial begin
    int lat;
    logic [IW-1:0] id;
    cmd_valid_i = 0; cmd_write_i = 0; cmd_id_i = '0; cmd_addr_i = '0; cmd_wdata_i = '0; cmd_wstrb_i = '0;
    rsp_ready_i = 0;
    slave_idle();
    #1 areset = 0;
    #2;
    chk("reset_ctl", {56'd0, cmd_ready_o, rsp_valid_o, awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, busy_o}, 64'd0);
    chk("reset_data_a", {awaddr_o, wdata_o}, 64'd0);
    chk("reset_data_b", {rsp_rdata_o, araddr_o}, 64'd0);
    chk("reset_ids", {44'd0, awid_o, wid_o, arid_o, rsp_id_o, rsp_resp_o, wstrb_o}, 64'd0);
    repeat (3) @(negedge clk);
    chk("reset_hold_ready", {63'd0, cmd_ready_o}, 64'd0);
    areset = 1;
    @(negedge clk);
    chk("ready_after_reset", {62'd0, cmd_ready_o, busy_o}, 64'b10);
`ifdef AXI_LITE_MASTER_ID_CHECK_EN
    chk("id_err_reset", {63'd0, id_err_o}, 64'd0);
`endif

    // Zero-wait write: response visible at cycle 3 after acceptance.
    do_write(4'd3, 32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 4'd3, 0, 1'b0, lat);
    chk("wr_latency", 64'(lat), 64'd3);
    // AW lags W by 4 cycles with early bvalid noise.
    do_write(4'd1, 32'h8, 32'hCAFE0001, 4'h3, 4, 0, 1, 2'b10, 4'd1, 0, 1'b1, lat);
    // Read with delayed AR and SLVERR.
    do_read(4'd5, 32'hC, 2, 0, 1, 32'h12345678, 2'b10, 4'd5, 0, lat);
    do_read(4'd6, 32'h10, 0, 0, 1, 32'h0BADF00D, 2'b00, 4'd6, 0, lat);
    chk("rd_latency", 64'(lat), 64'd3);
    // Backpressure with the next command already waiting.
    preload = 1;
    cmd_write_i = 1; cmd_id_i = 4'd9; cmd_addr_i = 32'h20; cmd_wdata_i = 32'h55AA55AA; cmd_wstrb_i = 4'hC;
    do_read(4'd7, 32'h14, 0, 1, 2, 32'hA5A5A5A5, 2'b00, 4'd7, 5, lat);
    preload = 0;
    do_write(4'd9, 32'h20, 32'h55AA55AA, 4'hC, 0, 0, 0, 2'b00, 4'd9, 0, 1'b0, lat);
    chk("preload_latency", 64'(lat), 64'd3);

    // Reset in the middle of a write.
    issue_cmd(1'b1, 4'd4, 32'h30, 32'h11112222, 4'hF);
    chk("mid_awvalid", {62'd0, awvalid_o, wvalid_o}, 64'b11);
    #2 areset = 0;
    #1;
    chk("mid_reset_ctl", {56'd0, cmd_ready_o, rsp_valid_o, awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, busy_o}, 64'd0);
    @(negedge clk);
    areset = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset", {61'd0, cmd_ready_o, rsp_valid_o, busy_o}, 64'b100);
    end

    // Randomized mix of writes and multi-beat reads.
    for (int n = 0; n < 30; n++) begin
      id = $urandom;
      if ($urandom_range(0, 1) == 1)
        do_write(id, $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), 2'($urandom_range(0, 3)), id, $urandom_range(0, 3), 1'b1, lat);
      else
        do_read(id, $urandom, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(1, 3),
                $urandom, 2'($urandom_range(0, 3)), id, $urandom_range(0, 3), lat);
    end

`ifdef AXI_LITE_MASTER_ID_CHECK_EN
    chk("id_err_clean", {63'd0, id_err_o}, 64'd0);
    do_write(4'd2, 32'h40, 32'h01020304, 4'hF, 0, 0, 0, 2'b00, 4'd7, 0, 1'b0, lat);
    chk("id_err_set", {63'd0, id_err_o}, 64'd1);
    do_read(4'd8, 32'h44, 0, 0, 1, 32'h99887766, 2'b00, 4'd8, 0, lat);
    chk("id_err_sticky", {63'd0, id_err_o}, 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
